// File: rtl/bits_unpack_p_if.sv
// rtl/bits_unpack_p_if.sv - word-in / bit-field-out bus for bits_unpack_p
interface bits_unpack_p_if #(
    parameter int IN_W        = 32,
    parameter int DEPTH_WORDS = 32,
    parameter int LEN_W       = 4,
    parameter int AV_W        = $clog2(IN_W * DEPTH_WORDS + 1)
);
    logic                    pushin;
    logic [IN_W-1:0]         datain;
    logic                    reqin;
    logic [LEN_W-1:0]        reqlen;
    logic                    flush;
    logic                    pushout;
    logic [LEN_W-1:0]        lenout;
    logic [2**LEN_W-2:0]     dataout;
    logic [AV_W-1:0]         avail;
    logic                    full;
    logic                    err;

    modport master (
        output pushin, datain, reqin, reqlen, flush,
        input  pushout, lenout, dataout, avail, full, err
    );

    modport slave (
        input  pushin, datain, reqin, reqlen, flush,
        output pushout, lenout, dataout, avail, full, err
    );
endinterface

// File: rtl/bits_unpack_p.sv
// rtl/bits_unpack_p.sv - circular bit buffer serving LSB-first variable-length bit requests
module bits_unpack_p #(
    parameter int IN_W        = 32,
    parameter int DEPTH_WORDS = 32,
    parameter int LEN_W       = 4,
    parameter int AV_W        = $clog2(IN_W * DEPTH_WORDS + 1)
) (
    input logic            clk,
    input logic            rst,
    bits_unpack_p_if.slave bus
);
    localparam int CAP    = IN_W * DEPTH_WORDS;
    localparam int MAXLEN = 2**LEN_W - 1;
    localparam int WA_W   = $clog2(DEPTH_WORDS);
    localparam int OFF_W  = $clog2(IN_W);
    localparam int RP_W   = $clog2(CAP);
    localparam logic [MAXLEN-1:0] ONES = '1;

    logic [IN_W-1:0]   mem_q [DEPTH_WORDS];
    logic [WA_W-1:0]   wptr_q, wptr_d;
    logic [RP_W-1:0]   rptr_q, rptr_d;
    logic [AV_W-1:0]   avail_q, avail_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              s1_vld_q, s1_vld_d;
    logic [LEN_W-1:0]  s1_len_q, s1_len_d;
    logic [MAXLEN-1:0] s1_data_q, s1_data_d;
    logic              pushout_q, pushout_d;
    logic [LEN_W-1:0]  lenout_q, lenout_d;
    logic [MAXLEN-1:0] dataout_q, dataout_d;

    logic              push_ok, req_ok;
    logic [WA_W-1:0]   rd_word, rd_next;
    logic [OFF_W-1:0]  rd_off;
    logic [2*IN_W-1:0] rd_pair;
    logic [MAXLEN-1:0] rd_field, len_mask;

    always_comb begin
        push_ok  = bus.pushin && !full_q && !bus.flush;
        req_ok   = bus.reqin && (AV_W'(bus.reqlen) <= avail_q) && !bus.flush;

        // A field is shorter than a word, so it touches at most this word and the next.
        rd_word  = rptr_q[RP_W-1:OFF_W];
        rd_off   = rptr_q[OFF_W-1:0];
        rd_next  = rd_word + WA_W'(1);
        rd_pair  = {mem_q[rd_next], mem_q[rd_word]};
        rd_field = MAXLEN'(rd_pair >> rd_off);
        len_mask = ~(ONES << bus.reqlen);

        wptr_d   = push_ok ? wptr_q + WA_W'(1) : wptr_q;
        rptr_d   = req_ok ? rptr_q + RP_W'(bus.reqlen) : rptr_q;
        avail_d  = avail_q + (push_ok ? AV_W'(IN_W) : '0) - (req_ok ? AV_W'(bus.reqlen) : '0);
        full_d   = avail_d > AV_W'(CAP - IN_W);
        err_d    = !bus.flush && ((bus.pushin && full_q) || (bus.reqin && !req_ok));

        s1_vld_d  = req_ok;
        s1_len_d  = req_ok ? bus.reqlen : s1_len_q;
        s1_data_d = req_ok ? (rd_field & len_mask) : s1_data_q;

        pushout_d = s1_vld_q && !bus.flush;
        lenout_d  = pushout_d ? s1_len_q : lenout_q;
        dataout_d = pushout_d ? s1_data_q : dataout_q;

        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            avail_d = '0;
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= bus.datain;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            avail_q   <= '0;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_len_q  <= '0;
            s1_data_q <= '0;
            pushout_q <= 1'b0;
            lenout_q  <= '0;
            dataout_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            avail_q   <= avail_d;
            full_q    <= full_d;
            err_q     <= err_d;
            s1_vld_q  <= s1_vld_d;
            s1_len_q  <= s1_len_d;
            s1_data_q <= s1_data_d;
            pushout_q <= pushout_d;
            lenout_q  <= lenout_d;
            dataout_q <= dataout_d;
        end
    end

    assign bus.pushout = pushout_q;
    assign bus.lenout  = lenout_q;
    assign bus.dataout = dataout_q;
    assign bus.avail   = avail_q;
    assign bus.full    = full_q;
    assign bus.err     = err_q;
endmodule
